// File: rtl/crypto_dispatch_mc.sv
// crypto_dispatch_mc: dispatches 128-bit blocks to an external AES or SM4
// core. It applies ECB/CBC chaining per channel, emits a one-cycle start
// pulse, waits for the selected core's done under a watchdog, and returns
// the result on a valid/ready stream with an error flag.
// Optional feature macro: CRYPTO_DISPATCH_STATS_EN adds the blk_cnt/err_cnt
// statistics output ports.
module crypto_dispatch_mc #(
    parameter int DATA_W      = 128,
    parameter int NUM_CH      = 4,
    parameter int CH_W        = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [CH_W-1:0]   s_ch,
    input  logic              s_algo,
    input  logic              s_cbc,
    input  logic              s_first,
    input  logic [DATA_W-1:0] s_iv,
    input  logic [DATA_W-1:0] s_din,
    output logic              aes_start,
    output logic              sm4_start,
    output logic [DATA_W-1:0] eng_din,
    input  logic              aes_done,
    input  logic [DATA_W-1:0] aes_dout,
    input  logic              sm4_done,
    input  logic [DATA_W-1:0] sm4_dout,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_dout,
    output logic [CH_W-1:0]   m_ch,
    output logic              m_err,
`ifdef CRYPTO_DISPATCH_STATS_EN
    output logic [31:0]       blk_cnt,
    output logic [15:0]       err_cnt,
`endif
    output logic              busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t             state_q;
    logic [CH_W-1:0]    ch_q;
    logic               algo_q;
    logic               cbc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  eng_din_q;
    logic               aes_start_q;
    logic               sm4_start_q;
    logic               m_valid_q;
    logic [DATA_W-1:0]  m_dout_q;
    logic [CH_W-1:0]    m_ch_q;
    logic               m_err_q;
    logic [DATA_W-1:0]  chain_q [NUM_CH];

    logic               ch_ok;
    logic [DATA_W-1:0]  chain_rd;
    logic [DATA_W-1:0]  chain_mix;
    logic               sel_done;
    logic [DATA_W-1:0]  sel_dout;
    logic               chain_wr;

    assign s_ready   = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign aes_start = aes_start_q;
    assign sm4_start = sm4_start_q;
    assign eng_din   = eng_din_q;
    assign m_valid   = m_valid_q;
    assign m_dout    = m_dout_q;
    assign m_ch      = m_ch_q;
    assign m_err     = m_err_q;

    assign ch_ok    = (32'(s_ch) < NUM_CH);
    assign sel_done = algo_q ? sm4_done : aes_done;
    assign sel_dout = algo_q ? sm4_dout : aes_dout;
    assign chain_wr = (state_q == S_WAIT) && sel_done && cbc_q;

    // Read the stored chain of the requested channel (out-of-range ids read 0).
    always_comb begin
        chain_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (s_ch == CH_W'(i)) begin
                chain_rd = chain_q[i];
            end
        end
    end

    // Chaining value XORed into the block: none for ECB, IV on first CBC block.
    always_comb begin
        if (!s_cbc) begin
            chain_mix = '0;
        end else if (s_first) begin
            chain_mix = s_iv;
        end else begin
            chain_mix = chain_rd;
        end
    end

    // Per-channel CBC chain registers, updated only by their own CBC results.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                chain_q[i] <= '0;
            end
        end else if (chain_wr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_q == CH_W'(i)) begin
                    chain_q[i] <= sel_dout;
                end
            end
        end
    end

    // Dispatcher FSM with registered start pulses and result outputs.
    // The chain register can only change while a block is in WAIT, so the
    // engine input is formed at accept time; only the fields needed later
    // (channel, algorithm, mode) are kept. The watchdog counts cycles since
    // the start pulse, so a hung core is reported TIMEOUT_CYC cycles after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ch_q        <= '0;
            algo_q      <= 1'b0;
            cbc_q       <= 1'b0;
            cnt_q       <= '0;
            eng_din_q   <= '0;
            aes_start_q <= 1'b0;
            sm4_start_q <= 1'b0;
            m_valid_q   <= 1'b0;
            m_dout_q    <= '0;
            m_ch_q      <= '0;
            m_err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (s_valid) begin
                        ch_q   <= s_ch;
                        algo_q <= s_algo;
                        cbc_q  <= s_cbc;
                        if (!ch_ok) begin
                            m_valid_q <= 1'b1;
                            m_dout_q  <= '0;
                            m_ch_q    <= s_ch;
                            m_err_q   <= 1'b1;
                            state_q   <= S_OUT;
                        end else begin
                            eng_din_q   <= s_din ^ chain_mix;
                            aes_start_q <= !s_algo;
                            sm4_start_q <= s_algo;
                            cnt_q       <= '0;
                            state_q     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    aes_start_q <= 1'b0;
                    sm4_start_q <= 1'b0;
                    cnt_q       <= cnt_q + CNT_W'(1);
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (sel_done) begin
                        m_valid_q <= 1'b1;
                        m_dout_q  <= sel_dout;
                        m_ch_q    <= ch_q;
                        m_err_q   <= 1'b0;
                        state_q   <= S_OUT;
                    end else if (cnt_q == CNT_LAST) begin
                        m_valid_q <= 1'b1;
                        m_dout_q  <= '0;
                        m_ch_q    <= ch_q;
                        m_err_q   <= 1'b1;
                        state_q   <= S_OUT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef CRYPTO_DISPATCH_STATS_EN
    logic [31:0] blk_cnt_q;
    logic [15:0] err_cnt_q;

    assign blk_cnt = blk_cnt_q;
    assign err_cnt = err_cnt_q;

    // Result statistics counted on the output handshake; error count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (m_valid_q && m_ready) begin
            if (m_err_q) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_q <= err_cnt_q + 16'd1;
                end
            end else begin
                blk_cnt_q <= blk_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crypto_dispatch_mc.sv
// Testbench for crypto_dispatch_mc: directed blocks with a scoreboard queue
// filled at issue time and drained by a monitor on the output handshake.
module tb_crypto_dispatch_mc;

    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] SM4K = {16{8'h5A}};

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [3:0]   s_ch;
    logic         s_algo;
    logic         s_cbc;
    logic         s_first;
    logic [127:0] s_iv;
    logic [127:0] s_din;
    logic         aes_start;
    logic         sm4_start;
    logic [127:0] eng_din;
    logic         aes_done;
    logic [127:0] aes_dout;
    logic         sm4_done;
    logic [127:0] sm4_dout;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_dout;
    logic [3:0]   m_ch;
    logic         m_err;
    logic         busy;
`ifdef CRYPTO_DISPATCH_STATS_EN
    logic [31:0]  blk_cnt;
    logic [15:0]  err_cnt;
`endif

    logic aes_done_m, aes_done_x, sm4_done_m;
    assign aes_done = aes_done_m | aes_done_x;
    assign sm4_done = sm4_done_m;

    crypto_dispatch_mc #(
        .DATA_W(128), .NUM_CH(4), .CH_W(4), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch), .s_algo(s_algo),
        .s_cbc(s_cbc), .s_first(s_first), .s_iv(s_iv), .s_din(s_din),
        .aes_start(aes_start), .sm4_start(sm4_start), .eng_din(eng_din),
        .aes_done(aes_done), .aes_dout(aes_dout),
        .sm4_done(sm4_done), .sm4_dout(sm4_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_dout(m_dout),
        .m_ch(m_ch), .m_err(m_err),
`ifdef CRYPTO_DISPATCH_STATS_EN
        .blk_cnt(blk_cnt), .err_cnt(err_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [127:0] dout;
        logic [3:0]   ch;
        logic         err;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] exp_chain [16];
    int           n_chk = 0;
    int           n_pass = 0;
    int           start_cyc = 0;
    int           resp_delay = 1;
    bit           hang = 1'b0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Core model: AES returns ~in, SM4 returns in ^ 0x5A..5A, resp_delay cycles after start.
    initial begin
        logic         sel;
        logic [127:0] e;
        aes_done_m = 1'b0;
        sm4_done_m = 1'b0;
        aes_dout   = '0;
        sm4_dout   = '0;
        forever begin
            @(negedge clk);
            if (!rst && (aes_start || sm4_start) && !hang) begin
                sel = sm4_start;
                e   = eng_din;
                repeat (resp_delay) @(posedge clk);
                #1;
                if (sel) begin sm4_dout = e ^ SM4K; sm4_done_m = 1'b1; end
                else     begin aes_dout = ~e;       aes_done_m = 1'b1; end
                @(posedge clk);
                #1;
                aes_done_m = 1'b0;
                sm4_done_m = 1'b0;
            end
        end
    end

    // Monitor: compare every output handshake against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_valid && m_ready) begin
                $display("out ch=%0d err=%0b dout=%h", m_ch, m_err, m_dout);
                if (sb.size() == 0) begin
                    check("unexpected_out", {127'b0, m_valid}, 128'd0);
                end else begin
                    e = sb.pop_front();
                    check("m_dout", m_dout, e.dout);
                    check("m_ch", {124'b0, m_ch}, {124'b0, e.ch});
                    check("m_err", {127'b0, m_err}, {127'b0, e.err});
                end
            end
        end
    end

    task automatic send(input logic [3:0] ch, input logic algo, input logic cbc,
                        input logic first, input logic [127:0] iv, input logic [127:0] din);
        logic [127:0] chain, eng, dout;
        exp_t e;
        int n = 0;
        bit ok;
        ok = (ch < 4);
        while (!s_ready && n < 200) begin @(posedge clk); #1; n++; end
        check("s_ready_wait", {127'b0, s_ready}, 128'd1);
        chain = !cbc ? 128'd0 : (first ? iv : exp_chain[ch]);
        eng   = din ^ chain;
        dout  = algo ? (eng ^ SM4K) : ~eng;
        e.ch  = ch;
        if (!ok || hang) begin
            e.err = 1'b1; e.dout = '0;
        end else begin
            e.err = 1'b0; e.dout = dout;
            if (cbc) exp_chain[ch] = dout;
        end
        sb.push_back(e);
        $display("in  ch=%0d algo=%0b cbc=%0b first=%0b din=%h", ch, algo, cbc, first, din);
        s_ch = ch; s_algo = algo; s_cbc = cbc; s_first = first; s_iv = iv; s_din = din;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        start_cyc = cyc;
        if (ok) begin
            check("aes_start", {127'b0, aes_start}, {127'b0, !algo});
            check("sm4_start", {127'b0, sm4_start}, {127'b0, algo});
            check("eng_din", eng_din, eng);
        end else begin
            check("no_start_bad_ch", {126'b0, aes_start, sm4_start}, 128'd0);
        end
        @(posedge clk);
        #1;
        check("start_one_pulse", {126'b0, aes_start, sm4_start}, 128'd0);
    endtask

    task automatic wait_valid(output int lat);
        int n = 0;
        while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("m_valid_wait", {127'b0, m_valid}, 128'd1);
        lat = cyc - start_cyc;
    endtask

    initial begin
        int lat;
        logic [127:0] held;
        bit seen;
        for (int i = 0; i < 16; i++) exp_chain[i] = '0;
        aes_done_x = 1'b0;
        rst = 1'b1; s_valid = 1'b0; s_ch = '0; s_algo = 1'b0; s_cbc = 1'b0;
        s_first = 1'b0; s_iv = '0; s_din = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_outputs", {123'b0, m_valid, busy, aes_start, sm4_start, m_err}, 128'd0);
        check("rst_s_ready", {127'b0, s_ready}, 128'd1);
        check("rst_m_dout", m_dout, 128'd0);

        // AES ECB, done 3 cycles after start
        resp_delay = 3;
        send(4'd0, 1'b0, 1'b0, 1'b0, '0, 128'd1);
        wait_valid(lat);
        check("aes_latency", 128'(lat), 128'd4);
        check("aes_hand_dout", m_dout, {ONES[127:1], 1'b0});
        resp_delay = 1;

        // SM4 CBC on channel 2
        send(4'd2, 1'b1, 1'b1, 1'b1, {16{8'hA5}}, '0);
        check("sm4_iv_eng", eng_din, {16{8'hA5}});
        send(4'd2, 1'b1, 1'b1, 1'b0, '0, {16{8'h0F}});
        check("sm4_chain_eng", eng_din, {16{8'hF0}});

        // Interleaved AES CBC on channels 1 and 3
        send(4'd1, 1'b0, 1'b1, 1'b1, {16{8'h11}}, '0);
        send(4'd3, 1'b0, 1'b1, 1'b1, {16{8'h33}}, '0);
        send(4'd1, 1'b0, 1'b1, 1'b0, '0, '0);
        check("ch1_chain_eng", eng_din, {16{8'hEE}});
        send(4'd3, 1'b0, 1'b1, 1'b0, '0, '0);
        check("ch3_chain_eng", eng_din, {16{8'hCC}});

        // Hung core: watchdog error, chain of channel 1 untouched
        hang = 1'b1;
        send(4'd1, 1'b0, 1'b1, 1'b0, '0, '0);
        wait_valid(lat);
        check("timeout_latency", 128'(lat), 128'd16);
        check("timeout_err", {127'b0, m_err}, 128'd1);
        hang = 1'b0;
        send(4'd1, 1'b0, 1'b1, 1'b0, '0, '0);
        check("chain_after_timeout", eng_din, {16{8'h11}});

        // Bad channel id
        send(4'd5, 1'b0, 1'b0, 1'b0, '0, 128'd7);

        // Back-pressure for 10 cycles
        m_ready = 1'b0;
        send(4'd0, 1'b1, 1'b0, 1'b0, '0, 128'h1234);
        wait_valid(lat);
        held = m_dout;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold_flags", {126'b0, m_valid, s_ready}, 128'd2);
            check("bp_hold_dout", m_dout, held);
        end
        m_ready = 1'b1;

        // Reset while waiting on a hung core, then a late done
        hang = 1'b1;
        send(4'd0, 1'b0, 1'b0, 1'b0, '0, 128'h55);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        for (int i = 0; i < 16; i++) exp_chain[i] = '0;
        check("midrst_outputs", {123'b0, m_valid, busy, aes_start, sm4_start, m_err}, 128'd0);
        check("midrst_m_dout", m_dout, 128'd0);
        check("midrst_m_ch", {124'b0, m_ch}, 128'd0);
        check("midrst_s_ready", {127'b0, s_ready}, 128'd1);
        aes_done_x = 1'b1;
        @(posedge clk);
        #1;
        aes_done_x = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (m_valid || busy) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("late_done_ignored", {127'b0, seen}, 128'd0);
        hang = 1'b0;
        send(4'd2, 1'b1, 1'b1, 1'b0, '0, {16{8'h0F}});
        check("chain_cleared_by_rst", eng_din, {16{8'h0F}});

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("sb_drained", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
